// File: rtl/color_space_pkg.sv
// Shared definitions for the colour-space converter.
// Holds the mode encoding, coefficient format, the three conversion
// matrices (rows = output channel, columns = input channel, values scaled by
// 2^COEF_FRAC) and a helper that picks one coefficient for a given mode.
package color_space_pkg;

  typedef enum logic [1:0] {
    CSC_BYPASS      = 2'd0,
    CSC_RGB2YCC_601 = 2'd1,
    CSC_RGB2YCC_709 = 2'd2,
    CSC_YCC2RGB_601 = 2'd3
  } csc_mode_e;

  localparam int COEF_FRAC   = 14;
  localparam int COEF_W      = 17;
  localparam int CSC_LATENCY = 4;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Rows: Y, Cb, Cr. Columns: R, G, B.
  localparam coef_t COEF_601_FWD [3][3] = '{
    '{ 17'sd4899,  17'sd9617,  17'sd1868},
    '{-17'sd2765, -17'sd5427,  17'sd8192},
    '{ 17'sd8192, -17'sd6860, -17'sd1332}
  };

  localparam coef_t COEF_709_FWD [3][3] = '{
    '{ 17'sd3483,  17'sd11718,  17'sd1183},
    '{-17'sd1877, -17'sd6315,   17'sd8192},
    '{ 17'sd8192, -17'sd7441,  -17'sd751}
  };

  // Rows: R, G, B. Columns: Y, Cb', Cr' (chroma already re-centred on zero).
  localparam coef_t COEF_601_INV [3][3] = '{
    '{ 17'sd16384,  17'sd0,      17'sd22970},
    '{ 17'sd16384, -17'sd5638,  -17'sd11700},
    '{ 17'sd16384,  17'sd29032,  17'sd0}
  };

  localparam coef_t COEF_UNITY = coef_t'(1 <<< COEF_FRAC);

  // Bypass is an identity matrix, so it rides the same datapath and latency;
  // (x * 2^14 + 2^13) >>> 14 returns x exactly.
  function automatic coef_t coef_sel(input csc_mode_e mode, input logic [1:0] row,
                                     input logic [1:0] col);
    case (mode)
      CSC_RGB2YCC_601: return COEF_601_FWD[row][col];
      CSC_RGB2YCC_709: return COEF_709_FWD[row][col];
      CSC_YCC2RGB_601: return COEF_601_INV[row][col];
      default:         return (row == col) ? COEF_UNITY : '0;
    endcase
  endfunction

endpackage

// File: rtl/csc_mac3.sv
// One output channel of the converter: three signed products, sum with
// optional chroma offset and rounding bias, then shift and clamp.
// Ports:
//   clk, rst     clock, synchronous active-high reset (output register only)
//   en           pipeline advance; all registers hold when low
//   x0..x2       stage-1 operands, signed DATA_W+1 bits
//   c0..c2       coefficients for the pixel held in the operand stage
//   add_ofs      add 2^(DATA_W-1) << COEF_FRAC for the pixel in the product stage
//   y            clamped DATA_W-bit result (pipeline output register)
module csc_mac3
  import color_space_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W:0]   x0,
  input  logic signed [DATA_W:0]   x1,
  input  logic signed [DATA_W:0]   x2,
  input  coef_t                    c0,
  input  coef_t                    c1,
  input  coef_t                    c2,
  input  logic                     add_ofs,
  output logic        [DATA_W-1:0] y
);

  localparam int XW = DATA_W + 1;
  localparam int PW = XW + COEF_W;
  localparam int AW = DATA_W + 20;

  localparam logic signed [AW-1:0] OFS  = AW'(1) <<< (DATA_W - 1 + COEF_FRAC);
  localparam logic signed [AW-1:0] MAXV = AW'((1 <<< DATA_W) - 1);

  function automatic logic signed [AW-1:0] round_bias();
    return AW'(1) <<< (COEF_FRAC - 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_clamp(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] q;
    q = acc >>> COEF_FRAC;
    if (q < 0)         return '0;
    else if (q > MAXV) return '1;
    else               return q[DATA_W-1:0];
  endfunction

  logic signed [PW-1:0] prod0_p1, prod1_p1, prod2_p1;
  logic signed [AW-1:0] acc_p2;

  // Stage 2: products
  always_ff @(posedge clk) begin
    if (en) begin
      prod0_p1 <= PW'(x0) * PW'(c0);
      prod1_p1 <= PW'(x1) * PW'(c1);
      prod2_p1 <= PW'(x2) * PW'(c2);
    end
  end

  // Stage 3: accumulate with offset and rounding bias
  always_ff @(posedge clk) begin
    if (en) begin
      acc_p2 <= AW'(prod0_p1) + AW'(prod1_p1) + AW'(prod2_p1)
              + (add_ofs ? OFS : AW'(0)) + round_bias();
    end
  end

  // Stage 4: shift and clamp into the output register
  always_ff @(posedge clk) begin
    if (rst)     y <= '0;
    else if (en) y <= shift_clamp(acc_p2);
  end

endmodule

// File: rtl/color_space_converter.sv
// Mode-selectable colour-space converter, one pixel (3 channels) per cycle,
// fixed 4-stage pipeline with valid/ready backpressure.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   mode_i               0 bypass, 1 RGB->YCbCr 601, 2 RGB->YCbCr 709, 3 YCbCr->RGB 601
//   s_valid_i/s_ready_o  input handshake; s_ready_o is the pipeline enable
//   s_sof_i, s_eol_i     frame/line markers; mode_i is latched on an accepted sof
//   s_data_i             {c2,c1,c0}
//   m_valid_o/m_ready_i  output handshake
//   m_sof_o, m_eol_o     markers aligned with m_data_o
//   m_data_o             converted {c2,c1,c0}
//   m_mode_o             mode the pixel on m_data_o was converted with
module color_space_converter
  import color_space_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic                  s_sof_i,
  input  logic                  s_eol_i,
  input  logic [3*DATA_W-1:0]   s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_sof_o,
  output logic                  m_eol_o,
  output logic [3*DATA_W-1:0]   m_data_o,
  output logic [1:0]            m_mode_o
);

  localparam int XW = DATA_W + 1;
  localparam logic signed [XW-1:0] HALF = XW'(1 <<< (DATA_W - 1));

  logic                 en;
  logic                 accept;
  csc_mode_e            frame_mode;
  csc_mode_e            beat_mode;
  logic signed [XW-1:0] opnd [3];

  logic                 vld_p0, vld_p1, vld_p2;
  logic                 sof_p0, sof_p1, sof_p2;
  logic                 eol_p0, eol_p1, eol_p2;
  csc_mode_e            mode_p0, mode_p1, mode_p2;
  logic signed [XW-1:0] x_p0 [3];
  logic [2:0]           ofs_p1;
  logic [DATA_W-1:0]    y_ch [3];

  // No bubble collapsing: the whole pipe moves or the whole pipe holds.
  assign en        = !m_valid_o || m_ready_i;
  assign s_ready_o = en;
  assign accept    = s_valid_i && en;

  // A sof beat takes the live mode; all other beats use the frame's mode.
  assign beat_mode = s_sof_i ? csc_mode_e'(mode_i) : frame_mode;

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      opnd[ch] = signed'({1'b0, s_data_i[ch*DATA_W +: DATA_W]});
      if (ch != 0 && beat_mode == CSC_YCC2RGB_601) opnd[ch] = opnd[ch] - HALF;
    end
  end

  // Control path: valids, markers, mode tags
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_mode <= CSC_RGB2YCC_601;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      m_valid_o  <= 1'b0;
      sof_p0     <= 1'b0;
      sof_p1     <= 1'b0;
      sof_p2     <= 1'b0;
      m_sof_o    <= 1'b0;
      eol_p0     <= 1'b0;
      eol_p1     <= 1'b0;
      eol_p2     <= 1'b0;
      m_eol_o    <= 1'b0;
      mode_p0    <= CSC_BYPASS;
      mode_p1    <= CSC_BYPASS;
      mode_p2    <= CSC_BYPASS;
      m_mode_o   <= 2'd0;
    end else begin
      if (accept && s_sof_i) frame_mode <= csc_mode_e'(mode_i);
      if (en) begin
        // Stage 1
        vld_p0    <= s_valid_i;
        sof_p0    <= s_sof_i;
        eol_p0    <= s_eol_i;
        mode_p0   <= beat_mode;
        // Stage 2
        vld_p1    <= vld_p0;
        sof_p1    <= sof_p0;
        eol_p1    <= eol_p0;
        mode_p1   <= mode_p0;
        // Stage 3
        vld_p2    <= vld_p1;
        sof_p2    <= sof_p1;
        eol_p2    <= eol_p1;
        mode_p2   <= mode_p1;
        // Stage 4
        m_valid_o <= vld_p2;
        m_sof_o   <= sof_p2;
        m_eol_o   <= eol_p2;
        m_mode_o  <= mode_p2;
      end
    end
  end

  // Stage 1: operand register
  always_ff @(posedge clk) begin
    if (en) begin
      for (int ch = 0; ch < 3; ch++) x_p0[ch] <= opnd[ch];
    end
  end

  // Chroma outputs of the forward transforms sit around mid-scale.
  always_comb begin
    ofs_p1 = 3'b000;
    if (mode_p1 == CSC_RGB2YCC_601 || mode_p1 == CSC_RGB2YCC_709) ofs_p1 = 3'b110;
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    csc_mac3 #(
      .DATA_W (DATA_W)
    ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .x0      (x_p0[0]),
      .x1      (x_p0[1]),
      .x2      (x_p0[2]),
      .c0      (coef_sel(mode_p0, 2'(ch), 2'd0)),
      .c1      (coef_sel(mode_p0, 2'(ch), 2'd1)),
      .c2      (coef_sel(mode_p0, 2'(ch), 2'd2)),
      .add_ofs (ofs_p1[ch]),
      .y       (y_ch[ch])
    );
  end

  assign m_data_o = {y_ch[2], y_ch[1], y_ch[0]};

endmodule

// File: tb/tb_color_space_converter.sv
module tb_color_space_converter;
  import color_space_pkg::*;

  localparam int W  = 8;
  localparam int W2 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      mode;
  logic            s_valid, s_ready, s_sof, s_eol;
  logic [3*W-1:0]  s_data;
  logic            m_valid, m_ready, m_sof, m_eol;
  logic [3*W-1:0]  m_data;
  logic [1:0]      m_mode;

  logic [1:0]      mode10;
  logic            s_valid10, s_ready10, s_sof10, s_eol10;
  logic [3*W2-1:0] s_data10;
  logic            m_valid10, m_ready10, m_sof10, m_eol10;
  logic [3*W2-1:0] m_data10;
  logic [1:0]      m_mode10;

  color_space_converter #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .mode_i(mode),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_sof_i(s_sof), .s_eol_i(s_eol),
    .s_data_i(s_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_sof_o(m_sof), .m_eol_o(m_eol),
    .m_data_o(m_data), .m_mode_o(m_mode)
  );

  color_space_converter #(.DATA_W(W2)) dut10 (
    .clk(clk), .rst(rst), .mode_i(mode10),
    .s_valid_i(s_valid10), .s_ready_o(s_ready10), .s_sof_i(s_sof10), .s_eol_i(s_eol10),
    .s_data_i(s_data10),
    .m_valid_o(m_valid10), .m_ready_i(m_ready10), .m_sof_o(m_sof10), .m_eol_o(m_eol10),
    .m_data_o(m_data10), .m_mode_o(m_mode10)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [3*W-1:0] data;
    logic           sof;
    logic           eol;
    logic [1:0]     md;
    int             c;
  } beat_t;

  beat_t outq[$];
  int    accq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (s_valid && s_ready && !rst) accq.push_back(cyc);
    if (m_valid && m_ready && !rst) outq.push_back('{m_data, m_sof, m_eol, m_mode, cyc});
  end

  function automatic logic [3*W-1:0] pix(input int c0, input int c1, input int c2);
    return {W'(c2), W'(c1), W'(c0)};
  endfunction

  function automatic logic [3*W2-1:0] pix10(input int c0, input int c1, input int c2);
    return {W2'(c2), W2'(c1), W2'(c0)};
  endfunction

  task automatic clear_logs();
    outq.delete();
    accq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic push(input logic [3*W-1:0] d, input logic sof, input logic eol,
                      input logic [1:0] md);
    bit ok;
    ok = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol; mode = md;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: s_ready_o stayed %b, required 1 within 50 cycles", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h required 0", m_data); end
    checks++; if ({m_sof, m_eol, m_mode} !== 4'b0) begin errors++; $display("FAIL reset_sideband: got %b required 0000", {m_sof, m_eol, m_mode}); end
    checks++; if (m_valid10 !== 1'b0 || m_data10 !== '0) begin errors++; $display("FAIL reset_dut10: got valid=%b data=%h required 0/0", m_valid10, m_data10); end
    @(posedge clk); #1;
  endtask

  // First beat has no sof: it must use the reset frame mode (601 forward).
  task automatic test_mode1();
    logic [3*W-1:0] exp_d [3];
    exp_d = '{pix(76, 85, 255), pix(255, 128, 128), pix(76, 85, 255)};
    clear_logs();
    push(pix(255, 0, 0),     1'b0, 1'b0, 2'd0);
    push(pix(255, 255, 255), 1'b1, 1'b0, 2'd1);
    push(pix(255, 0, 0),     1'b0, 1'b1, 2'd1);
    idle(8);
    checks++;
    if (outq.size() !== 3) begin errors++; $display("FAIL mode1_count: got %0d required 3", outq.size()); end
    for (int i = 0; i < 3 && i < outq.size(); i++) begin
      checks++;
      if (outq[i].data !== exp_d[i]) begin errors++; $display("FAIL mode1_data[%0d]: got %h required %h", i, outq[i].data, exp_d[i]); end
      checks++;
      if (outq[i].md !== 2'd1) begin errors++; $display("FAIL mode1_tag[%0d]: got %0d required 1", i, outq[i].md); end
      if (i < accq.size()) begin
        checks++;
        if (outq[i].c - accq[i] !== CSC_LATENCY) begin
          errors++; $display("FAIL mode1_latency[%0d]: got %0d required %0d", i, outq[i].c - accq[i], CSC_LATENCY);
        end
      end
    end
  endtask

  // Second beat carries mode_i=1 without sof, which must be ignored.
  task automatic test_mode3_bypass();
    logic [3*W-1:0] exp_d [3];
    logic [1:0]     exp_m [3];
    exp_d = '{pix(128, 128, 128), pix(255, 164, 255), pix(17, 34, 51)};
    exp_m = '{2'd3, 2'd3, 2'd0};
    clear_logs();
    push(pix(128, 128, 128), 1'b1, 1'b0, 2'd3);
    push(pix(255, 128, 255), 1'b0, 1'b1, 2'd1);
    push(pix(17, 34, 51),    1'b1, 1'b1, 2'd0);
    idle(8);
    checks++;
    if (outq.size() !== 3) begin errors++; $display("FAIL mode3_count: got %0d required 3", outq.size()); end
    for (int i = 0; i < 3 && i < outq.size(); i++) begin
      checks++;
      if (outq[i].data !== exp_d[i] || outq[i].md !== exp_m[i]) begin
        errors++; $display("FAIL mode3_bypass[%0d]: got %h/%0d required %h/%0d", i, outq[i].data, outq[i].md, exp_d[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    fork
      begin
        for (int i = 0; i < 6; i++)
          push(pix(i*10+1, i*10+2, i*10+3), (i == 0), (i == 2 || i == 5), 2'd0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++;
          if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready[%0d]: got %b required 0", k, s_ready); end
          checks++;
          if (m_valid !== 1'b1 || m_data !== pix(11, 12, 13) || m_sof !== 1'b0 || m_eol !== 1'b0) begin
            errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h sof=%b eol=%b required 1/%h/0/0", k, m_valid, m_data, m_sof, m_eol, pix(11, 12, 13));
          end
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    idle(10);
    checks++;
    if (outq.size() !== 6) begin errors++; $display("FAIL bp_count: got %0d required 6", outq.size()); end
    for (int i = 0; i < 6 && i < outq.size(); i++) begin
      checks++;
      if (outq[i].data !== pix(i*10+1, i*10+2, i*10+3) || outq[i].sof !== (i == 0) ||
          outq[i].eol !== (i == 2 || i == 5)) begin
        errors++; $display("FAIL bp_order[%0d]: got %h sof=%b eol=%b required %h sof=%b eol=%b", i, outq[i].data,
                           outq[i].sof, outq[i].eol, pix(i*10+1, i*10+2, i*10+3), (i == 0), (i == 2 || i == 5));
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [3*W-1:0] exp_d [3];
    logic [1:0]     exp_m [3];
    exp_d = '{pix(255, 128, 128), pix(76, 85, 255), pix(54, 99, 255)};
    exp_m = '{2'd1, 2'd1, 2'd2};
    clear_logs();
    push(pix(255, 255, 255), 1'b1, 1'b0, 2'd1);
    push(pix(255, 0, 0),     1'b0, 1'b1, 2'd2);
    push(pix(255, 0, 0),     1'b1, 1'b1, 2'd2);
    idle(8);
    checks++;
    if (outq.size() !== 3) begin errors++; $display("FAIL switch_count: got %0d required 3", outq.size()); end
    for (int i = 0; i < 3 && i < outq.size(); i++) begin
      checks++;
      if (outq[i].data !== exp_d[i] || outq[i].md !== exp_m[i]) begin
        errors++; $display("FAIL switch[%0d]: got %h/%0d required %h/%0d", i, outq[i].data, outq[i].md, exp_d[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_data_w10();
    int k;
    k = 0;
    s_valid10 = 1'b1; s_sof10 = 1'b1; s_eol10 = 1'b0; mode10 = 2'd1;
    s_data10  = pix10(1023, 1023, 1023);
    @(negedge clk);
    checks++;
    if (s_ready10 !== 1'b1) begin errors++; $display("FAIL w10_ready: got %b required 1", s_ready10); end
    @(posedge clk); #1;
    s_valid10 = 1'b0; s_sof10 = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (m_valid10) begin k = n; break; end
    end
    checks++;
    if (k !== CSC_LATENCY) begin errors++; $display("FAIL w10_latency: got %0d required %0d", k, CSC_LATENCY); end
    checks++;
    if (m_data10 !== pix10(1023, 512, 512) || m_mode10 !== 2'd1) begin
      errors++; $display("FAIL w10_white: got %h/%0d required %h/1", m_data10, m_mode10, pix10(1023, 512, 512));
    end
    idle(4);
  endtask

  task automatic test_reset_midstream();
    int seen;
    seen = 0;
    for (int i = 0; i < 4; i++) push(pix(200, 100, 50), (i == 0), 1'b0, 2'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_state: got v=%b d=%h rdy=%b required 0/0/1", m_valid, m_data, s_ready);
    end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midreset_flush: got %0d valid cycles required 0", seen); end
    checks++;
    if (outq.size() !== 0) begin errors++; $display("FAIL midreset_outputs: got %0d beats required 0", outq.size()); end
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0; m_ready = 1'b1;
    mode10 = 2'd0; s_valid10 = 1'b0; s_sof10 = 1'b0; s_eol10 = 1'b0; s_data10 = '0; m_ready10 = 1'b1;
    test_reset();
    test_mode1();
    test_mode3_bypass();
    test_backpressure();
    test_mode_switch();
    test_data_w10();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
